// File: rtl/loac_mem_pkg.sv
// Shared constants and types for the address sequencer that sits in front
// of the 4x4 combinational ROM.
package loac_mem_pkg;

    // Default geometry of the ROM behind the sequencer.
    localparam int ADDR_W_DEF = 2;
    localparam int DATA_W_DEF = 4;
    localparam int ROM_DEPTH  = 2 ** ADDR_W_DEF;

    // Sequencer states: wait for a request, present an address for one
    // cycle, hold the captured word until accepted, and flag completion.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/rom_scan_ctrl.sv
// Address sequencer and output register stage for the 4x4 combinational ROM.
// Performs a single read or a full burst scan, presents each word on a
// valid/ready stream and keeps a running XOR checksum of emitted words.
module rom_scan_ctrl
    import loac_mem_pkg::*;
#(
    parameter int  ADDR_W = ADDR_W_DEF,
    parameter int  DATA_W = DATA_W_DEF,
    localparam int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              burst,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              abort,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    state_t              state;
    state_t              next_state;
    logic [ADDR_W-1:0]   addr_reg;
    logic [ADDR_W-1:0]   cnt;

    // The ROM address comes straight from a register so it is glitch-free
    // for the whole FETCH cycle.
    assign rom_addr = addr_reg;

    // Next-state selection and state-decoded status outputs.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        next_state = state;
        busy       = (state != IDLE);
        done       = (state == DONE);
        unique case (state)
            IDLE: begin
                // abort has no meaning here, so start always wins.
                if (start) next_state = FETCH;
            end
            FETCH: begin
                next_state = abort ? IDLE : HOLD;
            end
            HOLD: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (out_ready) begin
                    next_state = (cnt == '0) ? DONE : FETCH;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // State register plus address, counter, output word and checksum updates.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state     <= IDLE;
            addr_reg  <= '0;
            cnt       <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            checksum  <= '0;
        end else begin
            state <= next_state;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        addr_reg <= burst ? '0 : addr_in;
                        cnt      <= burst ? ADDR_W'(DEPTH - 1) : '0;
                        checksum <= '0;
                    end
                end
                FETCH: begin
                    // abort cancels before the word is captured.
                    if (!abort) begin
                        data_out  <= rom_data;
                        checksum  <= checksum ^ rom_data;
                        out_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        // Termination is on cnt, so the address never wraps.
                        if (cnt != '0) begin
                            addr_reg <= addr_reg + ADDR_W'(1);
                            cnt      <= cnt - ADDR_W'(1);
                        end
                    end
                end
                DONE: begin
                    out_valid <= 1'b0;
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_scan_ctrl.sv
// Self-checking bench for rom_scan_ctrl: directed scenarios against the
// reference ROM contents, then randomized operations with random ROM
// contents and random back-pressure checked against a word-list model.
module tb_rom_scan_ctrl;
    import loac_mem_pkg::*;

    localparam int AW    = 2;
    localparam int DW    = 4;
    localparam int DEPTH = 4;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          start     = 1'b0;
    logic          burst     = 1'b0;
    logic [AW-1:0] addr_in   = '0;
    logic          abort     = 1'b0;
    logic          out_ready = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] data_out;
    logic          out_valid;
    logic          busy;
    logic          done;
    logic [DW-1:0] checksum;

    // Behavioural stand-in for RAM_ROM_4x4.
    logic [DW-1:0] rom [DEPTH];
    always_comb rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    rom_scan_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .burst     (burst),
        .addr_in   (addr_in),
        .abort     (abort),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum)
    );

    int            n_cmp = 0;
    int            n_err = 0;
    int            ndone;
    logic [DW-1:0] got_q [$];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] exp_ck;
    logic [DW-1:0] burst_exp [DEPTH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic b, input logic [AW-1:0] a);
        start   = 1'b1;
        burst   = b;
        addr_in = a;
        tick();
        start   = 1'b0;
        burst   = 1'b0;
        addr_in = '0;
    endtask

    // Expected word list and checksum straight from the operation's meaning.
    task automatic build_expected(input logic b, input logic [AW-1:0] a);
        exp_q.delete();
        if (b) begin
            for (int i = 0; i < DEPTH; i++) exp_q.push_back(rom[i]);
        end else begin
            exp_q.push_back(rom[a]);
        end
        exp_ck = '0;
        foreach (exp_q[i]) exp_ck ^= exp_q[i];
    endtask

    // Run until the block goes idle, collecting every accepted word.
    task automatic observe(input bit rand_ready, input int budget);
        int cyc = 0;
        bit fin = 1'b0;
        ndone = 0;
        while (!fin && cyc < budget) begin
            if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
            if (out_valid && out_ready) got_q.push_back(data_out);
            tick();
            cyc++;
            if (done) ndone++;
            if (!busy) fin = 1'b1;
        end
        check("op_terminates", 32'(fin), 32'd1);
    endtask

    task automatic compare_words(input string tag);
        check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_w%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    task automatic run_op(input string tag, input logic b, input logic [AW-1:0] a, input bit rand_ready);
        build_expected(b, a);
        got_q.delete();
        if (!rand_ready) out_ready = 1'b1;
        start_op(b, a);
        observe(rand_ready, 100);
        compare_words(tag);
        check({tag, "_done_cnt"}, 32'(ndone), 32'd1);
        check({tag, "_checksum"}, 32'(checksum), 32'(exp_ck));
    endtask

    initial begin
        rom[0] = 4'h4; rom[1] = 4'hC; rom[2] = 4'h6; rom[3] = 4'h7;
        burst_exp[0] = 4'h4; burst_exp[1] = 4'hC; burst_exp[2] = 4'h6; burst_exp[3] = 4'h7;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_checksum", 32'(checksum), 32'd0);
        check("rst_valid_busy_done", {29'd0, out_valid, busy, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Burst with out_ready high: one word every two cycles.
        out_ready = 1'b1;
        start_op(1'b1, '0);
        check("b1_fetch_busy", 32'(busy), 32'd1);
        check("b1_fetch_valid", 32'(out_valid), 32'd0);
        for (int k = 0; k < DEPTH; k++) begin
            tick();
            check($sformatf("b1_valid%0d", k), 32'(out_valid), 32'd1);
            check($sformatf("b1_data%0d", k), 32'(data_out), 32'(burst_exp[k]));
            check($sformatf("b1_addr%0d", k), 32'(rom_addr), 32'(k));
            check($sformatf("b1_nodone%0d", k), 32'(done), 32'd0);
            tick();
        end
        check("b1_done", 32'(done), 32'd1);
        check("b1_done_busy", 32'(busy), 32'd1);
        check("b1_checksum", 32'(checksum), 32'h9);
        tick();
        check("b1_idle_busy", 32'(busy), 32'd0);
        check("b1_idle_done", 32'(done), 32'd0);
        check("b1_ck_persist", 32'(checksum), 32'h9);

        // Single read at address 2.
        start_op(1'b0, 2'b10);
        check("s_fetch_valid", 32'(out_valid), 32'd0);
        tick();
        check("s_valid", 32'(out_valid), 32'd1);
        check("s_data", 32'(data_out), 32'h6);
        tick();
        check("s_done", 32'(done), 32'd1);
        check("s_checksum", 32'(checksum), 32'h6);
        tick();
        check("s_idle", {30'd0, busy, done}, 32'd0);

        // Burst with a three-cycle stall on the second word.
        start_op(1'b1, '0);
        tick();
        check("st_w0", 32'(data_out), 32'h4);
        tick();
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("st_data%0d", k), 32'(data_out), 32'hC);
            check($sformatf("st_valid%0d", k), 32'(out_valid), 32'd1);
            check($sformatf("st_addr%0d", k), 32'(rom_addr), 32'd1);
            tick();
        end
        check("st_data_end", 32'(data_out), 32'hC);
        out_ready = 1'b1;
        got_q.delete();
        got_q.push_back(4'h4);
        exp_q.delete();
        foreach (burst_exp[i]) exp_q.push_back(burst_exp[i]);
        observe(1'b0, 50);
        compare_words("st");
        check("st_done_cnt", 32'(ndone), 32'd1);
        check("st_checksum", 32'(checksum), 32'h9);

        // start during HOLD of the first burst word is ignored.
        start_op(1'b1, '0);
        tick();
        check("ig_w0", 32'(data_out), 32'h4);
        start   = 1'b1;
        burst   = 1'b0;
        addr_in = 2'd3;
        tick();
        start   = 1'b0;
        addr_in = '0;
        got_q.delete();
        got_q.push_back(4'h4);
        observe(1'b0, 50);
        compare_words("ig");
        check("ig_done_cnt", 32'(ndone), 32'd1);
        check("ig_checksum", 32'(checksum), 32'h9);

        // abort during HOLD of the third burst word.
        start_op(1'b1, '0);
        repeat (5) tick();
        check("ab_w2", 32'(data_out), 32'h6);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_valid", 32'(out_valid), 32'd0);
        check("ab_done", 32'(done), 32'd0);
        check("ab_checksum", 32'(checksum), 32'hE);
        tick();
        check("ab_done_after", 32'(done), 32'd0);
        check("ab_ck_persist", 32'(checksum), 32'hE);

        // Asynchronous reset mid-burst, then a single read at address 3.
        start_op(1'b1, '0);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_rom_addr", 32'(rom_addr), 32'd0);
        check("ar_data_out", 32'(data_out), 32'd0);
        check("ar_checksum", 32'(checksum), 32'd0);
        check("ar_valid_busy_done", {29'd0, out_valid, busy, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_op("ar_read3", 1'b0, 2'd3, 1'b0);
        check("ar_read3_val", 32'(checksum), 32'h7);

        // Randomized operations: random ROM contents and back-pressure.
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < DEPTH; i++) rom[i] = DW'($urandom);
            run_op($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), AW'($urandom), 1'b1);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
